// File: rtl/nonce_hub_if.sv
// nonce_hub bus bundle: slave nonce inputs plus the transmitter handshake.
// master = hub side, slave = sources/transmitter side.
interface nonce_hub_if #(
  parameter int SLAVES    = 1,
  parameter int FIFO_LOG2 = 3,
  parameter int CNT_WIDTH = 16
);
  logic [SLAVES*32-1:0] slave_nonces;
  logic [SLAVES-1:0]    new_nonces;
  logic                 serial_busy;
  logic [31:0]          golden_nonce;
  logic                 serial_send;
  logic [FIFO_LOG2:0]   fifo_level;
  logic [CNT_WIDTH-1:0] lost_count;

  modport master (
    input  slave_nonces,
    input  new_nonces,
    input  serial_busy,
    output golden_nonce,
    output serial_send,
    output fifo_level,
    output lost_count
  );

  modport slave (
    output slave_nonces,
    output new_nonces,
    output serial_busy,
    input  golden_nonce,
    input  serial_send,
    input  fifo_level,
    input  lost_count
  );
endinterface

// File: rtl/nonce_hub.sv
// nonce_hub: per-slave capture, round-robin arbiter, FIFO, paced TX FSM.
// Ports: hash_clk, rst_n (async low), bus (nonce_hub_if.master).
// Optional: define HUB_DEDUP_EN to drop a grant equal to the last push.
module nonce_hub #(
  parameter int SLAVES    = 1,
  parameter int FIFO_LOG2 = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic        hash_clk,
  input  logic        rst_n,
  nonce_hub_if.master bus
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PW    = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    WAIT
  } tx_state_e;

  logic [31:0]          cap_q [SLAVES];
  logic [31:0]          cap_d [SLAVES];
  logic [SLAVES-1:0]    pend_q, pend_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [31:0]          mem_q [DEPTH];
  logic [31:0]          mem_d [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]   level_q, level_d;
  logic [CNT_WIDTH-1:0] lost_q, lost_d;
  logic [31:0]          golden_q, golden_d;
  logic                 send_q, send_d;
  tx_state_e            state_q, state_d;

  logic                 found;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic [SLAVES-1:0]    gnt_oh;
  logic [31:0]          gnt_word;
  logic                 full;
  logic                 empty;
  logic                 drop;
  logic                 push;
  logic                 pop;

  assign full  = (level_q == (FIFO_LOG2+1)'(DEPTH));
  assign empty = (level_q == '0);

  // First pending slave at or after rr_ptr, wrapping modulo SLAVES.
  always_comb begin
    logic [PW:0] sum;
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int i = 0; i < SLAVES; i++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(SLAVES)) sum = sum - (PW+1)'(SLAVES);
      if (!found && pend_q[sum[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
  end

  assign gnt_vld  = found && !full;
  assign gnt_word = cap_q[gnt_idx];

  always_comb begin
    logic [PW:0] nxt;
    gnt_oh = '0;
    for (int i = 0; i < SLAVES; i++)
      gnt_oh[i] = gnt_vld && (gnt_idx == PW'(i));
    nxt = {1'b0, gnt_idx} + 1'b1;
    if (nxt >= (PW+1)'(SLAVES)) nxt = '0;
    rr_ptr_d = gnt_vld ? nxt[PW-1:0] : rr_ptr_q;
  end

  // Capture: a new strobe always wins the register; an un-granted
  // pending word being overwritten is a loss.
  always_comb begin
    cap_d  = cap_q;
    pend_d = pend_q;
    lost_d = lost_q;
    for (int i = 0; i < SLAVES; i++) begin
      if (bus.new_nonces[i]) begin
        cap_d[i]  = bus.slave_nonces[i*32 +: 32];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !gnt_oh[i] && lost_d != '1)
          lost_d = lost_d + 1'b1;
      end else if (gnt_oh[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

`ifdef HUB_DEDUP_EN
  logic [31:0] last_q, last_d;
  logic        last_vld_q, last_vld_d;

  assign drop = last_vld_q && (gnt_word == last_q);

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (push) begin
      last_d     = gnt_word;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign drop = 1'b0;
`endif

  assign push = gnt_vld && !drop;

  always_comb begin
    state_d  = state_q;
    golden_d = golden_q;
    send_d   = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !bus.serial_busy) begin
          pop      = 1'b1;
          golden_d = mem_q[rd_ptr_q];
          send_d   = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: state_d = GAP;
      // busy from the transmitter may not have risen yet
      GAP:  state_d = WAIT;
      WAIT: if (!bus.serial_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = gnt_word;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLAVES; i++) cap_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q   <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      lost_q   <= '0;
      golden_q <= '0;
      send_q   <= 1'b0;
      state_q  <= IDLE;
    end else begin
      cap_q    <= cap_d;
      mem_q    <= mem_d;
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      lost_q   <= lost_d;
      golden_q <= golden_d;
      send_q   <= send_d;
      state_q  <= state_d;
    end
  end

  assign bus.golden_nonce = golden_q;
  assign bus.serial_send  = send_q;
  assign bus.fifo_level   = level_q;
  assign bus.lost_count   = lost_q;
endmodule

// File: tb/tb_nonce_hub.sv
// Directed bench for nonce_hub: 4 slaves, 2-deep FIFO.
// Transmitter modelled as busy for busy_len cycles after each send.
module tb_nonce_hub;
  localparam int NS = 4;
  localparam int FL = 1;
  localparam int CW = 16;

  logic hash_clk = 1'b0;
  logic rst_n    = 1'b0;

  nonce_hub_if #(.SLAVES(NS), .FIFO_LOG2(FL), .CNT_WIDTH(CW)) bus ();

  nonce_hub #(.SLAVES(NS), .FIFO_LOG2(FL), .CNT_WIDTH(CW)) dut (
    .hash_clk (hash_clk),
    .rst_n    (rst_n),
    .bus      (bus.master)
  );

  always #5 hash_clk = ~hash_clk;

  int          passed = 0;
  int          total  = 0;
  int          busy_len = 0;
  int          busy_cnt = 0;
  logic        hold_busy = 1'b0;
  logic [31:0] sends [$];
  int          n0;
  int          exp_sends;
  logic [31:0] v [4];

  always @(posedge hash_clk)
    if (bus.serial_send === 1'b1) sends.push_back(bus.golden_nonce);

  always begin
    @(negedge hash_clk);
    #1;
    if (!rst_n) busy_cnt = 0;
    else if (bus.serial_send === 1'b1) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    bus.serial_busy = hold_busy || (busy_cnt > 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge hash_clk);
  endtask

  task automatic do_reset();
    @(negedge hash_clk);
    rst_n = 1'b0;
    bus.new_nonces = '0;
    hold_busy = 1'b0;
    busy_len = 0;
    tick(2);
    rst_n = 1'b1;
    sends.delete();
    tick(2);
  endtask

  initial begin
    bus.slave_nonces = '0;
    bus.new_nonces   = '0;
    tick(2);
    chk("rst_golden", bus.golden_nonce, 32'h0);
    chk("rst_send", 32'(bus.serial_send), 32'h0);
    chk("rst_level", 32'(bus.fifo_level), 32'h0);
    chk("rst_lost", 32'(bus.lost_count), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // latency: strobe -> send 3 cycles later
    bus.slave_nonces[31:0] = 32'hDEADBEEF;
    bus.new_nonces = 4'b0001;
    tick();
    bus.new_nonces = '0;
    chk("lat_t1_send", 32'(bus.serial_send), 32'h0);
    chk("lat_t1_level", 32'(bus.fifo_level), 32'h0);
    tick();
    chk("lat_t2_level", 32'(bus.fifo_level), 32'h1);
    chk("lat_t2_send", 32'(bus.serial_send), 32'h0);
    tick();
    chk("lat_t3_send", 32'(bus.serial_send), 32'h1);
    chk("lat_t3_word", bus.golden_nonce, 32'hDEADBEEF);
    chk("lat_t3_level", 32'(bus.fifo_level), 32'h0);
    tick();
    chk("lat_t4_send", 32'(bus.serial_send), 32'h0);
    chk("lat_hold", bus.golden_nonce, 32'hDEADBEEF);
    tick(4);
    chk("lat_count", 32'(sends.size()), 32'd1);

    // four slaves at once, slow transmitter
    do_reset();
    busy_len = 20;
    bus.slave_nonces = {32'h44, 32'h33, 32'h22, 32'h11};
    bus.new_nonces = 4'hF;
    tick();
    bus.new_nonces = '0;
    tick(150);
    chk("all4_count", 32'(sends.size()), 32'd4);
    chk("all4_w0", sends[0], 32'h11);
    chk("all4_w1", sends[1], 32'h22);
    chk("all4_w2", sends[2], 32'h33);
    chk("all4_w3", sends[3], 32'h44);
    chk("all4_lost", 32'(bus.lost_count), 32'h0);

    // FIFO full, capture overwrite
    do_reset();
    hold_busy = 1'b1;
    tick();
    v[0] = 32'h1000_0001;
    v[1] = 32'h1000_0002;
    v[2] = 32'h1000_0003;
    v[3] = 32'h1000_0004;
    for (int k = 0; k < 4; k++) begin
      bus.slave_nonces[31:0] = v[k];
      bus.new_nonces = 4'b0001;
      tick();
    end
    bus.new_nonces = '0;
    chk("full_level", 32'(bus.fifo_level), 32'd2);
    chk("full_lost", 32'(bus.lost_count), 32'd1);
    chk("full_nosend", 32'(sends.size()), 32'd0);
    tick();
    hold_busy = 1'b0;
    busy_len = 2;
    tick(40);
    chk("full_count", 32'(sends.size()), 32'd3);
    chk("full_w0", sends[0], v[0]);
    chk("full_w1", sends[1], v[1]);
    chk("full_w2", sends[2], v[3]);
    chk("full_lost_end", 32'(bus.lost_count), 32'd1);

    // round-robin between slaves 0 and 2
    do_reset();
    for (int k = 0; k < 12; k++) begin
      bus.slave_nonces = {32'h0, 32'hC000_0000 + 32'(k),
                          32'h0, 32'hA000_0000 + 32'(k)};
      bus.new_nonces = 4'b0101;
      tick();
    end
    bus.new_nonces = '0;
    tick(60);
    chk("rr_g0", sends[0] >> 28, 32'hA);
    chk("rr_g1", sends[1] >> 28, 32'hC);
    chk("rr_g2", sends[2] >> 28, 32'hA);
    chk("rr_g3", sends[3] >> 28, 32'hC);

    // reset while waiting on the transmitter
    do_reset();
    busy_len = 30;
    bus.slave_nonces = {32'h44, 32'h33, 32'h22, 32'h11};
    bus.new_nonces = 4'hF;
    tick();
    bus.new_nonces = '0;
    tick(7);
    chk("mid_pre_level", 32'(bus.fifo_level), 32'd2);
    chk("mid_pre_word", bus.golden_nonce, 32'h11);
    chk("mid_pre_count", 32'(sends.size()), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_golden", bus.golden_nonce, 32'h0);
    chk("mid_send", 32'(bus.serial_send), 32'h0);
    chk("mid_level", 32'(bus.fifo_level), 32'h0);
    chk("mid_lost", 32'(bus.lost_count), 32'h0);
    tick();
    rst_n = 1'b1;
    n0 = sends.size();
    tick(50);
    chk("mid_quiet", 32'(sends.size()), 32'(n0));

    // repeated word from one slave
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.slave_nonces[63:32] = (k < 2) ? 32'hCAFEBABE : 32'h1;
      bus.new_nonces = 4'b0010;
      tick();
      bus.new_nonces = '0;
      tick(10);
    end
    tick(10);
`ifdef HUB_DEDUP_EN
    exp_sends = 2;
`else
    exp_sends = 3;
`endif
    chk("dup_count", 32'(sends.size()), 32'(exp_sends));
    chk("dup_first", sends[0], 32'hCAFEBABE);
    chk("dup_last", sends[exp_sends-1], 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/nonce_hub.md
# nonce_hub

Parametrised result-collection hub for a miner cluster. Captures golden nonces from `SLAVES` sources, which may be local miners or external port receivers. Sources are arbitrated round-robin into a FIFO, then paced out one 32-bit word at a time to the shared `serial_transmit` via its send/busy handshake. Successor to the single-register hub core: it adds multi-slave buffering, fair arbitration, loss accounting and optional duplicate suppression.

## Interface
Parameters:
- `SLAVES`, 1, number of nonce sources (1..32)
- `FIFO_LOG2`, 3, log2 of FIFO depth (depth = 2^FIFO_LOG2 words)
- `CNT_WIDTH`, 16, width of the lost-nonce counter

Ports:
- `hash_clk` in 1: sole clock; all logic is on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `slave_nonces` in `SLAVES*32`: slave i's nonce at bits [i*32+31:i*32]
- `new_nonces` in `SLAVES`: per-slave valid strobe; each high cycle is one nonce event
- `serial_busy` in 1: transmitter busy
- `golden_nonce` out 32: word presented to the transmitter
- `serial_send` out 1: one-cycle send strobe
- `fifo_level` out `FIFO_LOG2+1`: current FIFO occupancy
- `lost_count` out `CNT_WIDTH`: saturating count of overwritten captures

## Operation
- **Capture stage:** each slave i has a 32-bit `cap[i]` and a `pend[i]` flag.
  - `new_nonces[i]` high: `cap[i]` <= the slave's word, `pend[i]` <= 1.
  - If `pend[i]` was already 1 and not granted that cycle, `lost_count` increments. It saturates at all-ones.
- **Arbiter:**
  - Runs when any `pend` is set and the FIFO is not full.
  - Grants the lowest index at or after `rr_ptr`, wrapping modulo `SLAVES`.
  - On a grant: `pend` of the winner clears, `cap` is pushed, and `rr_ptr` <= winner+1 (mod `SLAVES`).
  - One grant per cycle.
- **Simultaneous grant and new strobe on the same slave:** the old value is pushed; the new value is captured with `pend` = 1. Not counted as lost.
- **FIFO full:** no grant; `pend` flags and `cap` values are held. Loss occurs only through overwrite in the capture stage.
- **TX FSM:**
  - `IDLE`: if FIFO is non-empty and `serial_busy` = 0, then `golden_nonce` <= head, pop, go to `SEND`.
  - `SEND`: `serial_send` = 1 for exactly this cycle, then go to `GAP`.
  - `GAP`: one cycle with `serial_busy` ignored (covers the transmitter's busy rise latency), then go to `WAIT`.
  - `WAIT`: stay while `serial_busy` = 1; go to `IDLE` when it is 0.
- **Push and pop in the same cycle:** `fifo_level` is unchanged. A push to an empty FIFO is not poppable until the next cycle.
- **Hold:** `golden_nonce` holds its value between sends.
- **Reset (async, any time, including mid-send):**
  - Forced values: `golden_nonce` = 0, `serial_send` = 0, `fifo_level` = 0, `lost_count` = 0, state = `IDLE`, `rr_ptr` = 0, all `pend` = 0, FIFO pointers = 0.
  - Any in-flight word is discarded.

## Timing
- Strobe at cycle t → `pend` set at t+1 → push at the end of t+1 → FIFO non-empty at t+2 → `IDLE` loads at t+2 → `serial_send` high during t+3 with `golden_nonce` valid. Latency from strobe to send is 3 cycles with the transmitter idle and no contention.
- Minimum send spacing: 3 cycles plus the transmitter's busy duration.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `HUB_DEDUP_EN` defined:
  - A `last_pushed` register and valid flag are added; reset clears the valid flag.
  - A granted word equal to `last_pushed` (flag valid) is dropped. `pend` clears and `rr_ptr` advances as for a normal grant, but nothing is pushed and `lost_count` does not change.
  - Covers external slaves resending the same nonce.
- `HUB_DEDUP_EN` undefined: every granted word is pushed.

## Test plan
- Single slave, idle transmitter: strobe 0xDEADBEEF at cycle 10 → `serial_send` high at cycle 13, `golden_nonce` = 0xDEADBEEF, `fifo_level` back to 0.
- `SLAVES`=4, all strobe in the same cycle with 0x11, 0x22, 0x33, 0x44; transmitter busy 20 cycles per word → sends 0x11, 0x22, 0x33, 0x44 in order, `lost_count` = 0.
- `FIFO_LOG2`=1, transmitter held busy, slave 0 strobes 4 distinct values on consecutive grants → FIFO holds 2, the third is held in `cap`, the fourth overwrites it → `lost_count` = 1. Release busy → exactly 3 words sent.
- Round-robin fairness: slaves 0 and 2 strobe every cycle, FIFO draining → grants alternate 0, 2, 0, 2; neither starves.
- `rst_n` pulsed low during `WAIT` with 3 words queued → all outputs return to reset values immediately, with no further `serial_send` until a new strobe.
- `HUB_DEDUP_EN` build: slave 1 sends 0xCAFEBABE twice, then 0x1 → exactly two sends (0xCAFEBABE, 0x1). Without the macro → three sends.
